// File: rtl/mod15_seq_checker.sv
// Receive-side integrity checker for the mod-15 up/down counter: golden-model prediction,
// one-cycle-late compare, saturating error count and sticky FAULT. Optional MOD15_CHK_RANGE_EN adds range_err.
module mod15_seq_checker #(
  parameter int ERR_CNT_W = 8,
  parameter int MAX_MISS  = 3,
  parameter int TOP_VAL   = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dut_rst,
  input  logic                 mode,
  input  logic                 load,
  input  logic [3:0]           data,
  input  logic [3:0]           cnt_in,
  input  logic                 clr_fault,
  output logic [3:0]           expected,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 locked,
  output logic                 fault
`ifdef MOD15_CHK_RANGE_EN
  ,
  output logic                 range_err
`endif
);

  typedef enum logic [1:0] {ACQUIRE, TRACK, FAULT} state_t;

  localparam logic [3:0] TOP      = 4'(TOP_VAL);
  localparam logic [3:0] MISS_LIM = 4'(MAX_MISS);

  state_t         state, state_nxt;
  logic [3:0]     streak, streak_nxt, streak_inc;
  logic [3:0]     nxt;
  logic           active, mismatch, range_hit;
  logic [1:0]     inc_n;
  logic [ERR_CNT_W:0] inc_w, cnt_sum;

  // Golden model: dut_rst > load > terminal wrap > direction, all modulo 16.
  always_comb begin
    if (dut_rst)           nxt = 4'd0;
    else if (load)         nxt = data;
    else if (cnt_in == TOP) nxt = 4'd0;
    else if (mode)         nxt = cnt_in + 4'd1;
    else                   nxt = cnt_in - 4'd1;
  end

  always_comb begin
    active     = (state != ACQUIRE);
    mismatch   = active && (cnt_in != expected);
`ifdef MOD15_CHK_RANGE_EN
    range_hit  = active && (cnt_in == 4'hF);
`else
    range_hit  = 1'b0;
`endif
    // A range hit and a mismatch in the same cycle each count once.
    inc_n      = {1'b0, mismatch} + {1'b0, range_hit};
    inc_w      = '0;
    inc_w[1:0] = inc_n;
    cnt_sum    = {1'b0, err_count} + inc_w;
    streak_inc = streak + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACQUIRE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    case (state)
      ACQUIRE: begin
        state_nxt  = TRACK;
        streak_nxt = '0;
      end
      TRACK: begin
        if (mismatch) begin
          streak_nxt = streak_inc;
          if (streak_inc >= MISS_LIM) state_nxt = FAULT;
        end else begin
          streak_nxt = '0;
        end
      end
      FAULT: begin
        if (clr_fault) begin
          state_nxt  = ACQUIRE;
          streak_nxt = '0;
        end
      end
      default: begin
        state_nxt  = ACQUIRE;
        streak_nxt = '0;
      end
    endcase
  end

  always_comb begin
    locked = (state == TRACK);
    fault  = (state == FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expected  <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
      streak    <= '0;
    end else begin
      expected  <= nxt;
      err_pulse <= mismatch;
      streak    <= streak_nxt;
      if (cnt_sum[ERR_CNT_W]) err_count <= '1;
      else                    err_count <= cnt_sum[ERR_CNT_W-1:0];
    end
  end

`ifdef MOD15_CHK_RANGE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) range_err <= 1'b0;
    else     range_err <= range_hit;
  end
`endif

endmodule

// File: tb/tb_mod15_seq_checker.sv
// Table-driven bench for mod15_seq_checker plus hand sequences for fault, saturation and async reset.
module tb_mod15_seq_checker;

  logic       clk = 1'b0;
  logic       rst, dut_rst, mode, load, clr_fault;
  logic [3:0] data, cnt_in;
  logic [3:0] expected;
  logic       err_pulse, locked, fault;
  logic [7:0] err_count;
`ifdef MOD15_CHK_RANGE_EN
  logic       range_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod15_seq_checker #(.ERR_CNT_W(8), .MAX_MISS(3), .TOP_VAL(14)) dut (
    .clk(clk), .rst(rst), .dut_rst(dut_rst), .mode(mode), .load(load),
    .data(data), .cnt_in(cnt_in), .clr_fault(clr_fault),
    .expected(expected), .err_pulse(err_pulse), .err_count(err_count),
    .locked(locked), .fault(fault)
`ifdef MOD15_CHK_RANGE_EN
    , .range_err(range_err)
`endif
  );

  typedef struct {
    logic       dr, md, ld;
    logic [3:0] dt, cnt;
    logic       clr;
    logic [3:0] e_exp;
    logic       e_pul;
    int         e_cnt;
    logic       e_lk, e_ft;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic dr, logic md, logic ld, logic [3:0] dt, logic [3:0] cnt,
                              logic clr, logic [3:0] e_exp, logic e_pul, int e_cnt,
                              logic e_lk, logic e_ft);
    vec_t v;
    v.dr = dr; v.md = md; v.ld = ld; v.dt = dt; v.cnt = cnt; v.clr = clr;
    v.e_exp = e_exp; v.e_pul = e_pul; v.e_cnt = e_cnt; v.e_lk = e_lk; v.e_ft = e_ft;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic drive(logic dr, logic md, logic ld, logic [3:0] dt, logic [3:0] cnt, logic clr);
    dut_rst = dr; mode = md; load = ld; data = dt; cnt_in = cnt; clr_fault = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(string tag, int e_exp, int e_pul, int e_cnt, int e_lk, int e_ft);
    chk({tag, ".expected"},  int'(expected),  e_exp);
    chk({tag, ".err_pulse"}, int'(err_pulse), e_pul);
    chk({tag, ".err_count"}, int'(err_count), e_cnt);
    chk({tag, ".locked"},    int'(locked),    e_lk);
    chk({tag, ".fault"},     int'(fault),     e_ft);
  endtask

  initial begin
    int extra;
    int ec;
    logic prev_active;

    // up-count 0..14, wrap to 0
    for (int k = 0; k <= 14; k++)
      add(0, 1, 0, 0, 4'(k), 0, (k == 14) ? 4'd0 : 4'(k + 1), 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    // load 3, then down-count through 0 -> 15 and terminal wrap 14 -> 0
    add(0, 1, 1, 3, 1, 0, 3, 0, 0, 1, 0);
    add(0, 0, 0, 0, 3, 0, 2, 0, 0, 1, 0);
    add(0, 0, 0, 0, 2, 0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 15, 0, 0, 1, 0);
    add(0, 0, 0, 0, 15, 0, 14, 0, 0, 1, 0);
    add(0, 0, 0, 0, 14, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 15, 0, 0, 1, 0);
    add(0, 0, 1, 5, 15, 0, 5, 0, 0, 1, 0);
    // load 9 while at 5; dut_rst beats everything
    add(0, 1, 1, 9, 5, 0, 9, 0, 0, 1, 0);
    add(0, 1, 0, 0, 9, 0, 10, 0, 0, 1, 0);
    add(1, 1, 1, 7, 10, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 0, 1, 0, 2, 0, 0, 1, 0);
    add(0, 1, 0, 0, 2, 0, 3, 0, 0, 1, 0);
    add(0, 1, 0, 0, 3, 0, 4, 0, 0, 1, 0);
    // single miss (7 vs 4), recovery clears the streak
    add(0, 1, 0, 0, 7, 0, 8, 1, 1, 1, 0);
    add(0, 1, 0, 0, 8, 0, 9, 0, 1, 1, 0);
    // three consecutive misses -> FAULT; compare continues in FAULT
    add(0, 1, 0, 0, 0, 0, 1, 1, 2, 1, 0);
    add(0, 1, 0, 0, 5, 0, 6, 1, 3, 1, 0);
    add(0, 1, 0, 0, 2, 0, 3, 1, 4, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1, 1, 5, 0, 1);
    // clr_fault -> ACQUIRE -> TRACK, count retained; clr_fault in TRACK ignored
    add(0, 1, 0, 0, 1, 1, 2, 0, 5, 0, 0);
    add(0, 1, 0, 0, 9, 0, 10, 0, 5, 1, 0);
    add(0, 1, 0, 0, 10, 0, 11, 0, 5, 1, 0);
    add(0, 1, 0, 0, 11, 1, 12, 0, 5, 1, 0);

    rst = 1'b1;
    drive(0, 1, 0, 0, 0, 0);
    step(); step();
    chk_all("reset", 0, 0, 0, 0, 0);
`ifdef MOD15_CHK_RANGE_EN
    chk("reset.range_err", int'(range_err), 0);
`endif
    rst = 1'b0;

    extra = 0;
    prev_active = 1'b0;
    foreach (vecs[i]) begin
      int e_cnt;
      drive(vecs[i].dr, vecs[i].md, vecs[i].ld, vecs[i].dt, vecs[i].cnt, vecs[i].clr);
`ifdef MOD15_CHK_RANGE_EN
      if (prev_active && vecs[i].cnt == 4'hF) extra++;
`endif
      step();
      e_cnt = vecs[i].e_cnt + extra;
      chk_all($sformatf("vec%0d", i), vecs[i].e_exp, vecs[i].e_pul, e_cnt, vecs[i].e_lk, vecs[i].e_ft);
`ifdef MOD15_CHK_RANGE_EN
      chk($sformatf("vec%0d.range_err", i), int'(range_err),
          (prev_active && vecs[i].cnt == 4'hF) ? 1 : 0);
`endif
      prev_active = vecs[i].e_lk | vecs[i].e_ft;
    end

    // constant cnt_in=5 with mode=1 predicts 6 -> miss every cycle
    ec = 5 + extra;
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 0, 5, 0);
      step();
      ec++;
      chk_all($sformatf("refault%0d", k), 6, 1, ec, (k < 2) ? 1 : 0, (k == 2) ? 1 : 0);
    end
    // mismatch and clr_fault together: leave FAULT but still record the miss
    drive(0, 1, 0, 0, 5, 1);
    step();
    ec++;
    chk_all("clr_with_miss", 6, 1, ec, 0, 0);
    drive(0, 1, 0, 0, 5, 0);
    step();
    chk_all("acquire_no_cmp", 6, 0, ec, 1, 0);

    // saturate err_count at all-ones
    for (int k = 0; k < 260; k++) begin
      drive(0, 1, 0, 0, 5, 0);
      step();
    end
    chk_all("saturate", 6, 1, 255, 0, 1);

    // asynchronous rst in FAULT takes effect without a clock edge
    rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    drive(0, 1, 0, 0, 0, 0);
    step();
    chk_all("post_rst", 1, 0, 0, 1, 0);

`ifdef MOD15_CHK_RANGE_EN
    // 15 in TRACK: range strobe plus a mismatch (expected 1), both counted
    drive(0, 1, 0, 0, 15, 0);
    step();
    chk("range.range_err", int'(range_err), 1);
    chk("range.err_count", int'(err_count), 2);
    chk("range.expected", int'(expected), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
